// File: rtl/nb_pkg.sv
// rtl/nb_pkg.sv - shared parameters, state type and helpers for the NBin fill/read sequencers
//
// Contents:
//   N, Tn, ADDR, NUM_WORDS  geometry of the Tn-lane offset latch buffer
//   LANE_W                  width of a lane index
//   fill_state_t            IDLE / FILL / DONE
//   clamp_len()             limits a requested per-lane length to NUM_WORDS

package nb_pkg;

   localparam int N         = 16;
   localparam int Tn        = 16;
   localparam int ADDR      = 6;
   localparam int NUM_WORDS = 64;
   localparam int LANE_W    = $clog2(Tn);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

   // Requested lengths above the lane depth are treated as a full-depth fill.
   function automatic logic [ADDR:0] clamp_len(input logic [ADDR:0] len);
      if (len > (ADDR+1)'(NUM_WORDS))
         return (ADDR+1)'(NUM_WORDS);
      return len;
   endfunction

endpackage

// File: rtl/nb_fill_ctrl_if.sv
// rtl/nb_fill_ctrl_if.sv - control, input stream and lane write bus of the NBin fill sequencer
//
// Signals:
//   i_start, i_base, i_len, i_abort   fill control from the host side
//   i_valid, i_data, o_ready          input word stream (accepted on i_valid & o_ready)
//   o_wen, o_wr_addr, o_data          per-lane latch write port
//   o_busy, o_done                    status
// Modports:
//   master  drives control and stream (host / DMA side)
//   slave   the sequencer itself

interface nb_fill_ctrl_if;
   import nb_pkg::*;

   logic                i_start;
   logic [ADDR-1:0]     i_base;
   logic [ADDR:0]       i_len;
   logic                i_abort;
   logic                i_valid;
   logic [N-1:0]        i_data;
   logic                o_ready;
   logic [Tn-1:0]       o_wen;
   logic [Tn*ADDR-1:0]  o_wr_addr;
   logic [Tn*N-1:0]     o_data;
   logic                o_busy;
   logic                o_done;

   modport master (
      output i_start, i_base, i_len, i_abort, i_valid, i_data,
      input  o_ready, o_wen, o_wr_addr, o_data, o_busy, o_done
   );

   modport slave (
      input  i_start, i_base, i_len, i_abort, i_valid, i_data,
      output o_ready, o_wen, o_wr_addr, o_data, o_busy, o_done
   );

endinterface

// File: rtl/nb_lane_cursor.sv
// rtl/nb_lane_cursor.sv - lane/word cursor walking Tn lanes per word up to a programmed length
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         return cursor to lane 0, word 0 (wins over adv)
//   adv         step to the next lane; after the last lane, next word
//   len         words per lane (1..NUM_WORDS while walking)
//   lane        current lane index
//   word        current word offset
//   last        cursor sits on the final lane of the final word

module nb_lane_cursor
   import nb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              adv,
   input  logic [ADDR:0]     len,
   output logic [LANE_W-1:0] lane,
   output logic [ADDR-1:0]   word,
   output logic              last
);

   logic lane_wrap;

   assign lane_wrap = (lane == LANE_W'(Tn - 1));
   assign last      = lane_wrap && ({1'b0, word} == (len - (ADDR+1)'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane <= '0;
         word <= '0;
      end else if (clr) begin
         lane <= '0;
         word <= '0;
      end else if (adv) begin
         if (lane_wrap) begin
            lane <= '0;
            word <= word + ADDR'(1);
         end else begin
            lane <= lane + LANE_W'(1);
         end
      end
   end

endmodule

// File: rtl/nb_fill_ctrl.sv
// rtl/nb_fill_ctrl.sv - write-side sequencer filling the Tn-lane NBin offset latch buffer
//
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    nb_fill_ctrl_if.slave: start/base/len/abort control, i_valid/i_data/o_ready
//          input stream, o_wen/o_wr_addr/o_data lane write port, o_busy/o_done status
//
// Input word k lands in lane k%Tn at address base + k/Tn (mod NUM_WORDS), one cycle
// after its handshake. Address and data are broadcast to all lanes; o_wen selects one.

module nb_fill_ctrl
   import nb_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   nb_fill_ctrl_if.slave bus
);

   fill_state_t        state;
   logic [ADDR-1:0]    base_q;
   logic [ADDR:0]      len_q;
   logic [ADDR:0]      start_len;

   logic [LANE_W-1:0]  lane;
   logic [ADDR-1:0]    word;
   logic               last;
   logic               accept;
   logic               cur_clr;

   logic [Tn-1:0]      wen_q;
   logic [ADDR-1:0]    addr_q;
   logic [N-1:0]       data_q;
   logic               done_q;

   // Abort masks ready combinationally so an abort beats a same-cycle valid word.
   assign bus.o_ready = (state == FILL) && !bus.i_abort;
   assign accept      = bus.i_valid && bus.o_ready;
   assign cur_clr     = (state == IDLE) && bus.i_start;
   assign start_len   = clamp_len(bus.i_len);

   nb_lane_cursor u_cursor (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cur_clr),
      .adv   (accept),
      .len   (len_q),
      .lane  (lane),
      .word  (word),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         base_q <= '0;
         len_q  <= '0;
         wen_q  <= '0;
         addr_q <= '0;
         data_q <= '0;
         done_q <= 1'b0;
      end else begin
         // Write enable and done are pulses; address and data hold between writes.
         wen_q  <= '0;
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  base_q <= bus.i_base;
                  len_q  <= start_len;
                  if (start_len == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= FILL;
                  end
               end
            end
            FILL: begin
               if (bus.i_abort) begin
                  state <= IDLE;
               end else if (accept) begin
                  wen_q  <= Tn'(1) << lane;
                  addr_q <= base_q + word;
                  data_q <= bus.i_data;
                  // Done is raised alongside the final write enable.
                  if (last) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_wen     = wen_q;
   assign bus.o_wr_addr = {Tn{addr_q}};
   assign bus.o_data    = {Tn{data_q}};
   assign bus.o_busy    = (state != IDLE);
   assign bus.o_done    = done_q;

endmodule

// File: tb/tb_nb_fill_ctrl.sv
// tb/tb_nb_fill_ctrl.sv - self-checking bench for nb_fill_ctrl against a word-index reference model

module tb_nb_fill_ctrl;
   import nb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   nb_fill_ctrl_if bus();

   nb_fill_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Observed writes, in order, plus done-pulse bookkeeping.
   int              obs_lane[$];
   logic [ADDR-1:0] obs_addr[$];
   logic [N-1:0]    obs_data[$];
   logic [N-1:0]    sent[$];
   int              done_cnt;
   int              done_at;
   bit              done_with_wen;
   int              onehot_bad;
   int              bcast_bad;

   always @(negedge clk) begin
      if (bus.o_wen != '0) begin
         if (!$onehot(bus.o_wen)) onehot_bad++;
         for (int l = 0; l < Tn; l++) begin
            if (bus.o_wen[l]) begin
               obs_lane.push_back(l);
               obs_addr.push_back(bus.o_wr_addr[l*ADDR +: ADDR]);
               obs_data.push_back(bus.o_data[l*N +: N]);
            end
            if (bus.o_wr_addr[l*ADDR +: ADDR] !== bus.o_wr_addr[ADDR-1:0] ||
                bus.o_data[l*N +: N] !== bus.o_data[N-1:0]) bcast_bad++;
         end
      end
      if (bus.o_done) begin
         done_cnt++;
         done_at = obs_lane.size();
         done_with_wen = (bus.o_wen != '0);
      end
   end

   task automatic clear_obs();
      obs_lane.delete(); obs_addr.delete(); obs_data.delete(); sent.delete();
      done_cnt = 0; done_at = -1; done_with_wen = 0; onehot_bad = 0; bcast_bad = 0;
   endtask

   // Called at posedge+1; returns at posedge+1.
   task automatic start_fill(input int base, input int len);
      bus.i_start = 1'b1;
      bus.i_base  = ADDR'(base);
      bus.i_len   = (ADDR+1)'(len);
      @(posedge clk); #1;
      bus.i_start = 1'b0;
   endtask

   task automatic send_words(input int total, input int gap_pct, output int cycles);
      int k = 0;
      cycles = 0;
      while (k < total && cycles < 20000) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            bus.i_valid = 1'b0;
         end else begin
            bus.i_valid = 1'b1;
            bus.i_data  = N'($urandom);
         end
         @(negedge clk);
         if (bus.i_valid && bus.o_ready) begin
            sent.push_back(bus.i_data);
            k++;
         end
         @(posedge clk); #1;
         cycles++;
      end
      bus.i_valid = 1'b0;
      checks++;
      if (k != total) begin
         errors++;
         $display("FAIL send_timeout accepted=%0d required=%0d", k, total);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference: word k -> lane k%Tn, addr (base + k/Tn) mod NUM_WORDS, data sent[k].
   task automatic test_reset();
      int cyc;
      int nbad;
      @(negedge clk);
      checks++;
      if (bus.o_wen !== '0 || bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state wen=%h ready=%b busy=%b done=%b required all zero",
                  bus.o_wen, bus.o_ready, bus.o_busy, bus.o_done);
      end
      @(posedge clk); #1;
      clear_obs();
      start_fill(7, 64);
      send_words(10, 0, cyc);
      @(negedge clk); #1;
      bus.i_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_wen !== '0 || bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset wen=%h ready=%b busy=%b done=%b required all zero",
                  bus.o_wen, bus.o_ready, bus.o_busy, bus.o_done);
      end
      checks++;
      if (obs_lane.size() != 10 || done_cnt != 0) begin
         errors++;
         $display("FAIL reset_partial writes=%0d done=%0d required 10 and 0", obs_lane.size(), done_cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.i_valid = 1'b0;
      wait_cycles(2);
      clear_obs();
      start_fill(3, 1);
      send_words(Tn, 0, cyc);
      wait_cycles(3);
      checks++;
      if (obs_lane.size() != Tn || done_cnt != 1 || done_at != Tn) begin
         errors++;
         $display("FAIL restart_count writes=%0d done=%0d at=%0d required %0d 1 %0d",
                  obs_lane.size(), done_cnt, done_at, Tn, Tn);
      end
      nbad = 0;
      for (int k = 0; k < obs_lane.size() && k < sent.size(); k++) begin
         checks++;
         if (obs_lane[k] !== k % Tn || obs_addr[k] !== ADDR'((3 + k / Tn) % NUM_WORDS) || obs_data[k] !== sent[k]) begin
            errors++;
            if (nbad++ < 4) $display("FAIL restart_map k=%0d lane=%0d addr=%0d data=%h required %0d %0d %h",
                                     k, obs_lane[k], obs_addr[k], obs_data[k], k % Tn, (3 + k / Tn) % NUM_WORDS, sent[k]);
         end
      end
   endtask

   task automatic test_full_fill();
      int cyc;
      int nbad;
      clear_obs();
      start_fill(0, 64);
      send_words(64 * Tn, 0, cyc);
      wait_cycles(3);
      checks++;
      if (cyc != 64 * Tn) begin
         errors++;
         $display("FAIL full_throughput cycles=%0d required %0d", cyc, 64 * Tn);
      end
      checks++;
      if (obs_lane.size() != 64 * Tn || done_cnt != 1 || done_at != 64 * Tn || !done_with_wen) begin
         errors++;
         $display("FAIL full_done writes=%0d done=%0d at=%0d with_wen=%0b required %0d 1 %0d 1",
                  obs_lane.size(), done_cnt, done_at, done_with_wen, 64 * Tn, 64 * Tn);
      end
      checks++;
      if (onehot_bad != 0 || bcast_bad != 0) begin
         errors++;
         $display("FAIL full_lanes onehot_bad=%0d bcast_bad=%0d required 0 0", onehot_bad, bcast_bad);
      end
      nbad = 0;
      for (int k = 0; k < obs_lane.size() && k < sent.size(); k++) begin
         checks++;
         if (obs_lane[k] !== k % Tn || obs_addr[k] !== ADDR'((k / Tn) % NUM_WORDS) || obs_data[k] !== sent[k]) begin
            errors++;
            if (nbad++ < 4) $display("FAIL full_map k=%0d lane=%0d addr=%0d data=%h required %0d %0d %h",
                                     k, obs_lane[k], obs_addr[k], obs_data[k], k % Tn, k / Tn, sent[k]);
         end
      end
   endtask

   task automatic test_wrap();
      int cyc;
      int nbad;
      clear_obs();
      start_fill(62, 4);
      send_words(4 * Tn, 0, cyc);
      wait_cycles(3);
      checks++;
      if (obs_lane.size() != 4 * Tn || done_cnt != 1 || done_at != 4 * Tn) begin
         errors++;
         $display("FAIL wrap_count writes=%0d done=%0d at=%0d required %0d 1 %0d",
                  obs_lane.size(), done_cnt, done_at, 4 * Tn, 4 * Tn);
      end
      nbad = 0;
      for (int k = 0; k < obs_lane.size() && k < sent.size(); k++) begin
         checks++;
         if (obs_lane[k] !== k % Tn || obs_addr[k] !== ADDR'((62 + k / Tn) % NUM_WORDS) || obs_data[k] !== sent[k]) begin
            errors++;
            if (nbad++ < 4) $display("FAIL wrap_map k=%0d lane=%0d addr=%0d data=%h required %0d %0d %h",
                                     k, obs_lane[k], obs_addr[k], obs_data[k], k % Tn, (62 + k / Tn) % NUM_WORDS, sent[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      int nbad;
      int base;
      base = $urandom_range(0, NUM_WORDS - 1);
      clear_obs();
      start_fill(base, 8);
      send_words(8 * Tn, 40, cyc);
      wait_cycles(3);
      checks++;
      if (obs_lane.size() != 8 * Tn || done_cnt != 1 || done_at != 8 * Tn || onehot_bad != 0) begin
         errors++;
         $display("FAIL bp_count writes=%0d done=%0d at=%0d onehot_bad=%0d required %0d 1 %0d 0",
                  obs_lane.size(), done_cnt, done_at, onehot_bad, 8 * Tn, 8 * Tn);
      end
      nbad = 0;
      for (int k = 0; k < obs_lane.size() && k < sent.size(); k++) begin
         checks++;
         if (obs_lane[k] !== k % Tn || obs_addr[k] !== ADDR'((base + k / Tn) % NUM_WORDS) || obs_data[k] !== sent[k]) begin
            errors++;
            if (nbad++ < 4) $display("FAIL bp_map k=%0d lane=%0d addr=%0d data=%h required %0d %0d %h",
                                     k, obs_lane[k], obs_addr[k], obs_data[k], k % Tn, (base + k / Tn) % NUM_WORDS, sent[k]);
         end
      end
   endtask

   task automatic test_abort();
      int cyc;
      clear_obs();
      start_fill(0, 64);
      send_words(20, 0, cyc);
      bus.i_valid = 1'b1;
      bus.i_data  = N'($urandom);
      bus.i_abort = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b0 || bus.o_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_ready ready=%b done=%b required 0 0", bus.o_ready, bus.o_done);
      end
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      bus.i_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle busy=%b required 0", bus.o_busy);
      end
      wait_cycles(3);
      checks++;
      if (obs_lane.size() != 20 || done_cnt != 0) begin
         errors++;
         $display("FAIL abort_count writes=%0d done=%0d required 20 0", obs_lane.size(), done_cnt);
      end
   endtask

   task automatic test_edge_lengths();
      int cyc;
      int nbad;
      // Empty fill
      clear_obs();
      start_fill(9, 0);
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_wen !== '0) begin
         errors++;
         $display("FAIL len0_done done=%b busy=%b wen=%h required 1 1 0", bus.o_done, bus.o_busy, bus.o_wen);
      end
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || obs_lane.size() != 0) begin
         errors++;
         $display("FAIL len0_after done=%b busy=%b writes=%0d required 0 0 0", bus.o_done, bus.o_busy, obs_lane.size());
      end
      @(posedge clk); #1;
      // Oversized length clamps to NUM_WORDS
      clear_obs();
      start_fill(20, 100);
      send_words(64 * Tn, 0, cyc);
      @(negedge clk);
      checks++;
      if (bus.o_done !== 1'b1) begin
         errors++;
         $display("FAIL clamp_done done=%b required 1", bus.o_done);
      end
      @(negedge clk);
      checks++;
      if (bus.o_ready !== 1'b0 || bus.o_busy !== 1'b0) begin
         errors++;
         $display("FAIL clamp_stop ready=%b busy=%b required 0 0", bus.o_ready, bus.o_busy);
      end
      wait_cycles(2);
      checks++;
      if (obs_lane.size() != 64 * Tn || done_cnt != 1 || done_at != 64 * Tn) begin
         errors++;
         $display("FAIL clamp_count writes=%0d done=%0d at=%0d required %0d 1 %0d",
                  obs_lane.size(), done_cnt, done_at, 64 * Tn, 64 * Tn);
      end
      nbad = 0;
      for (int k = 0; k < obs_lane.size() && k < sent.size(); k++) begin
         checks++;
         if (obs_lane[k] !== k % Tn || obs_addr[k] !== ADDR'((20 + k / Tn) % NUM_WORDS) || obs_data[k] !== sent[k]) begin
            errors++;
            if (nbad++ < 4) $display("FAIL clamp_map k=%0d lane=%0d addr=%0d data=%h required %0d %0d %h",
                                     k, obs_lane[k], obs_addr[k], obs_data[k], k % Tn, (20 + k / Tn) % NUM_WORDS, sent[k]);
         end
      end
      // Start while busy is ignored
      clear_obs();
      start_fill(10, 2);
      bus.i_start = 1'b1;
      bus.i_base  = ADDR'(40);
      bus.i_len   = (ADDR+1)'(1);
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      send_words(2 * Tn, 0, cyc);
      wait_cycles(3);
      checks++;
      if (obs_lane.size() != 2 * Tn || done_cnt != 1 || done_at != 2 * Tn) begin
         errors++;
         $display("FAIL busy_start_count writes=%0d done=%0d at=%0d required %0d 1 %0d",
                  obs_lane.size(), done_cnt, done_at, 2 * Tn, 2 * Tn);
      end
      nbad = 0;
      for (int k = 0; k < obs_lane.size() && k < sent.size(); k++) begin
         checks++;
         if (obs_lane[k] !== k % Tn || obs_addr[k] !== ADDR'((10 + k / Tn) % NUM_WORDS) || obs_data[k] !== sent[k]) begin
            errors++;
            if (nbad++ < 4) $display("FAIL busy_start_map k=%0d lane=%0d addr=%0d data=%h required %0d %0d %h",
                                     k, obs_lane[k], obs_addr[k], obs_data[k], k % Tn, (10 + k / Tn) % NUM_WORDS, sent[k]);
         end
      end
   endtask

   initial begin
      bus.i_start = 1'b0;
      bus.i_base  = '0;
      bus.i_len   = '0;
      bus.i_abort = 1'b0;
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      clear_obs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_reset();
      test_full_fill();
      test_wrap();
      test_backpressure();
      test_abort();
      test_edge_lengths();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout time=%0t required finish before 2000000", $time);
      $fatal(1);
   end

endmodule
